multi_channel_comparator: RTL and testbench
===========================================

// Module: multi_channel_comparator
// PURPOSE
//   Parametrised successor of the two-channel 3-bit equality comparator.
//   Compares CHANNELS independent pairs of WIDTH-bit operands (a[i] vs b[i]) under a selectable mode.
//   Result is registered behind a valid/ready handshake; per-channel saturating match counters
//   and a sticky mismatch flag are kept. Sits between operand producers and the status/check logic.
// PARAMETERS
//   WIDTH     3   operand width per channel, bits (>=1)
//   CHANNELS  2   number of compare lanes (>=1)
//   CNT_W     8   width of each per-channel match counter (>=1)
// PORTS
//   clk              in   1                clock, rising edge
//   reset_n          in   1                asynchronous reset, active-low
//   in_valid         in   1                operand set valid
//   in_ready         out  1                block can accept operands
//   mode             in   2                00 EQ, 01 NE, 10 LT (a<b), 11 GT (a>b); unsigned
//   a                in   CHANNELS*WIDTH   lane i = a[i*WIDTH +: WIDTH]
//   b                in   CHANNELS*WIDTH   lane i = b[i*WIDTH +: WIDTH]
//   clr              in   1                sync clear of counters and sticky flag
//   out_valid        out  1                result register holds a result
//   out_ready        in   1                consumer accepts result
//   y                out  CHANNELS         per-lane compare result (1 = mode condition true)
//   all_true         out  1                AND of y, registered with y
//   match_cnt        out  CHANNELS*CNT_W   lane i = count of accepted results with y[i]=1
//   mismatch_sticky  out  1                set once any accepted result had y != all-ones
// BEHAVIOUR
//   - Reset (reset_n=0, async): out_valid=0, y=0, all_true=0, match_cnt=0, mismatch_sticky=0.
//     in_ready is combinational and reads 1 while in reset. Reset mid-transfer discards the held result.
//   - in_ready = !out_valid || out_ready (1-deep output register, no combinational in->out path).
//   - Accept when in_valid && in_ready: y, all_true loaded next edge; out_valid=1; latency 1 cycle.
//   - out_valid cleared on out_valid && out_ready && !accept; simultaneous drain+accept keeps out_valid=1
//     and loads the new result (full throughput, 1 result/cycle).
//   - While out_valid && !out_ready: y, all_true held stable; in_ready=0; a/b/mode ignored.
//   - mode is sampled with a/b at accept; mode change while stalled has no effect on the held result.
//   - Counters/sticky update on accept (not on drain): match_cnt[i] += y_next[i], saturates at 2^CNT_W-1.
//     mismatch_sticky |= (y_next != all-ones).
//   - clr=1: counters and sticky go to 0 next edge. Overrides an accept in the same cycle
//     (that accept's result still loads into y/out_valid but is not counted).
//   - clr does not affect out_valid/y.
//   - State per lane: idle/holding given by shared out_valid. No further FSM.
//   - Width rules: compare unsigned, full WIDTH bits; no sign extension; counters never wrap.
// STRUCTURE
//   - Package cmp_pkg: localparams MODE_EQ=2'b00, MODE_NE=2'b01, MODE_LT=2'b10, MODE_GT=2'b11.
//   - Sub-module comparator_lane (WIDTH, CNT_W): combinational compare of one pair under mode,
//     plus its saturating counter with inc/clr inputs.
//   - Top: generate CHANNELS lanes, handshake register, all_true, sticky flag.
// TESTING
//   1. Reset: reset_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, in_ready=1.
//   2. EQ, defaults: a={3'd5,3'd2}, b={3'd5,3'd3} -> y=2'b10, all_true=0, sticky=1, match_cnt={1,0}.
//   3. Modes: a=3'd7, b=3'd0 per lane; LT -> y=00, GT -> y=11, NE -> y=11, EQ -> y=00, each 1 cycle after accept.
//   4. Backpressure: out_ready=0 for 5 cycles after accept -> in_ready=0, y stable; then out_ready=1
//      with new in_valid -> back-to-back results, no loss or duplicate count.
//   5. Saturation: CNT_W=2, 5 accepted EQ matches on lane 0 -> match_cnt[0]=3, holds at 3.
//   6. clr with simultaneous accept -> counters=0, sticky=0 next cycle, y shows the accepted result.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: compare-mode encodings shared by the comparator lanes and top.
package cmp_pkg;
    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_GT = 2'b11;
endpackage

// File: rtl/comparator_lane.sv
// comparator_lane: unsigned compare of one operand pair plus its saturating match counter.
module comparator_lane
    import cmp_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inc,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        y = (mode == MODE_EQ) ? (a == b) :
            (mode == MODE_NE) ? (a != b) :
            (mode == MODE_LT) ? (a < b) : (a > b);
        cnt_d = clr ? '0 : (inc && y && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/multi_channel_comparator.sv
// multi_channel_comparator: CHANNELS parallel compare lanes behind a 1-deep valid/ready
// result register, with per-lane match counters and a sticky mismatch flag.
module multi_channel_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    input  logic                      clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       y,
    output logic                      all_true,
    output logic [CHANNELS*CNT_W-1:0] match_cnt,
    output logic                      mismatch_sticky
);
    logic [CHANNELS-1:0] y_c, y_d, y_q;
    logic                accept, out_valid_d, out_valid_q, all_true_d, all_true_q, sticky_d, sticky_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        comparator_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .mode   (mode),
            .a      (a[i*WIDTH +: WIDTH]),
            .b      (b[i*WIDTH +: WIDTH]),
            .inc    (accept),
            .clr    (clr),
            .y      (y_c[i]),
            .cnt    (match_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        y_d         = accept ? y_c : y_q;
        all_true_d  = accept ? &y_c : all_true_q;
        out_valid_d = accept || (out_valid_q && !out_ready);
        sticky_d    = clr ? 1'b0 : sticky_q || (accept && y_c != '1);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            y_q         <= '0;
            all_true_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            y_q         <= y_d;
            all_true_q  <= all_true_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
        end

    assign y               = y_q;
    assign all_true        = all_true_q;
    assign out_valid       = out_valid_q;
    assign mismatch_sticky = sticky_q;
endmodule

// File: tb/tb_multi_channel_comparator.sv
// tb_multi_channel_comparator: directed table-driven check of the comparator, with a
// second CNT_W=2 instance on the same stimulus for counter saturation.
module tb_multi_channel_comparator;
    logic        clk = 0, reset_n = 0, in_valid = 0, out_ready = 1, clr = 0;
    logic [1:0]  mode = 2'b00;
    logic [5:0]  a = '0, b = '0;
    logic        in_ready, out_valid, all_true, sticky;
    logic [1:0]  y;
    logic [15:0] match_cnt;
    logic        in_ready2, out_valid2, all_true2, sticky2;
    logic [1:0]  y2;
    logic [3:0]  match_cnt2;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    multi_channel_comparator dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .all_true(all_true), .match_cnt(match_cnt), .mismatch_sticky(sticky)
    );

    multi_channel_comparator #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2), .mode(mode),
        .a(a), .b(b), .clr(clr), .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
        .all_true(all_true2), .match_cnt(match_cnt2), .mismatch_sticky(sticky2)
    );

    typedef struct {
        logic [1:0] mode;
        logic [5:0] a;
        logic [5:0] b;
        logic [1:0] y;
        logic       all;
    } vec_t;
    vec_t tbl[8];

    logic [7:0] m8[2];
    logic [1:0] m2[2];
    logic       ms;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [5:0] aa, input logic [5:0] bb);
        mode = m; a = aa; b = bb; in_valid = 1;
    endtask

    task automatic upd(input logic [1:0] yy);
        for (int i = 0; i < 2; i++)
            if (yy[i]) begin
                if (m8[i] != 8'hff) m8[i]++;
                if (m2[i] != 2'd3) m2[i]++;
            end
        ms |= (yy != 2'b11);
    endtask

    task automatic mclr();
        m8[0] = 0; m8[1] = 0; m2[0] = 0; m2[1] = 0; ms = 0;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"}, 32'(match_cnt), 32'({m8[1], m8[0]}));
        chk({tag, "_cnt2"}, 32'(match_cnt2), 32'({m2[1], m2[0]}));
        chk({tag, "_sticky"}, 32'(sticky), 32'(ms));
    endtask

    initial begin
        tbl[0] = '{2'b10, {3'd7, 3'd7}, {3'd0, 3'd0}, 2'b00, 1'b0};
        tbl[1] = '{2'b11, {3'd7, 3'd7}, {3'd0, 3'd0}, 2'b11, 1'b1};
        tbl[2] = '{2'b01, {3'd7, 3'd7}, {3'd0, 3'd0}, 2'b11, 1'b1};
        tbl[3] = '{2'b00, {3'd7, 3'd7}, {3'd0, 3'd0}, 2'b00, 1'b0};
        tbl[4] = '{2'b00, {3'd3, 3'd3}, {3'd3, 3'd3}, 2'b11, 1'b1};
        tbl[5] = '{2'b10, {3'd1, 3'd6}, {3'd2, 3'd6}, 2'b10, 1'b0};
        tbl[6] = '{2'b11, {3'd0, 3'd4}, {3'd7, 3'd3}, 2'b01, 1'b0};
        tbl[7] = '{2'b01, {3'd0, 3'd0}, {3'd0, 3'd0}, 2'b00, 1'b0};
        mclr();

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        reset_n = 1;
        cyc();

        drive(2'b00, {3'd5, 3'd2}, {3'd5, 3'd3});
        cyc();
        upd(2'b10);
        in_valid = 0;
        chk("eq_y", 32'(y), 32'b10);
        chk("eq_all", 32'(all_true), 0);
        chk_cnt("eq");
        cyc();
        chk("eq_drain", 32'(out_valid), 0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].mode, tbl[i].a, tbl[i].b);
            cyc();
            upd(tbl[i].y);
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].y));
            chk($sformatf("vec%0d_all", i), 32'(all_true), 32'(tbl[i].all));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
        end
        in_valid = 0;
        cyc();
        chk("tbl_drain", 32'(out_valid), 0);
        chk_cnt("tbl");

        out_ready = 0;
        drive(2'b00, {3'd3, 3'd3}, {3'd3, 3'd3});
        cyc();
        upd(2'b11);
        drive(2'b01, {3'd1, 3'd2}, {3'd1, 3'd3});
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 0);
            chk($sformatf("bp%0d_y", i), 32'(y), 32'b11);
            cyc();
            mode = 2'(i);
        end
        chk("bp_valid", 32'(out_valid), 1);
        chk_cnt("bp_hold");
        mode = 2'b01;
        out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        cyc();
        upd(2'b01);
        in_valid = 0;
        chk("bp_next_y", 32'(y), 32'b01);
        chk("bp_next_valid", 32'(out_valid), 1);
        cyc();
        chk("bp_drain", 32'(out_valid), 0);
        chk_cnt("bp");

        clr = 1;
        cyc();
        clr = 0;
        mclr();
        drive(2'b00, {3'd1, 3'd4}, {3'd2, 3'd4});
        for (int i = 0; i < 5; i++) begin
            cyc();
            upd(2'b01);
        end
        in_valid = 0;
        chk("sat_lane0", 32'(match_cnt2[1:0]), 3);
        chk_cnt("sat");
        cyc();
        chk("sat_hold", 32'(match_cnt2[1:0]), 3);

        clr = 1;
        drive(2'b00, {3'd2, 3'd2}, {3'd2, 3'd2});
        cyc();
        mclr();
        clr = 0;
        in_valid = 0;
        chk("clr_y", 32'(y), 32'b11);
        chk("clr_valid", 32'(out_valid), 1);
        chk_cnt("clr");
        drive(2'b00, {3'd1, 3'd1}, {3'd1, 3'd2});
        cyc();
        upd(2'b10);
        in_valid = 0;
        chk_cnt("post_clr");

        out_ready = 0;
        drive(2'b11, {3'd7, 3'd7}, {3'd0, 3'd0});
        cyc();
        in_valid = 0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_y", 32'(y), 0);
        chk("arst_all", 32'(all_true), 0);
        chk("arst_cnt", 32'(match_cnt), 0);
        chk("arst_sticky", 32'(sticky), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        #10 reset_n = 1;
        out_ready = 1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
